// File: rtl/shift_add_mult4_pkg.sv
// Shared definitions for the shift-add multiplier: operand width and FSM states.
package shift_add_mult4_pkg;

    // Operand width; tied to the 4-bit ripple adder slice.
    localparam int MULT_WIDTH = 4;

    // Controller states. Encoding 2'd3 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple4bit.sv
// 4-bit ripple-carry adder: S = A + B + C0, carry out on Cout.
module ripple4bit (
    input  logic       C0,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] S,
    output logic       Cout
);

    logic carry;

    // Chain of full adders, carry rippling from bit 0 upward.
    always_comb begin
        carry = C0;
        S     = '0;
        for (int i = 0; i < 4; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned multiplier. One ripple adder is reused over four
// shift-add iterations; the product is registered and held until the next op.
//
// Handshake: start is sampled only at a rising edge where ready=1 (IDLE).
// Accepted start moves to RUN for four cycles, then DONE for one cycle where
// done=1 and P is valid. start while ready=0 is dropped, never queued.
module shift_add_mult4
    import shift_add_mult4_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    // Iteration count follows the operand width; not meant to be overridden.
    localparam int ITER = WIDTH;
    localparam logic [1:0] LAST_CNT = 2'(ITER - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    // Partial product for this iteration: multiplicand gated by the multiplier LSB.
    assign add_b = q_q[0] ? m_q : '0;

    ripple4bit u_adder (1'b0, acc_q, add_b, sum, cout);

    // State and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Next-state and datapath update: capture, four shift-add steps, one done cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Carry shifts into the accumulator MSB so no product bit is lost.
                acc_d = {cout, sum[WIDTH-1:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_CNT) begin
                    p_d     = {acc_d, q_d};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        ready = (state_q == S_IDLE);
        busy  = (state_q == S_RUN) || (state_q == S_DONE);
        done  = (state_q == S_DONE);
    end

    assign P = p_q;

endmodule
